// File: rtl/pcihellocore_hexport_arbiter.sv
// Two-master arbiter sharing the hex display PIO slave between the PCI host (m0)
// and a local requester (m1); one transaction per grant, registered slave side.
module pcihellocore_hexport_arbiter #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 2,
  parameter int ROUND_ROBIN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_chipselect,
  input  logic              m0_write_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_waitrequest,
  input  logic              m1_chipselect,
  input  logic              m1_write_n,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_waitrequest,
  output logic              s_chipselect,
  output logic              s_write_n,
  output logic [ADDR_W-1:0] s_address,
  output logic [DATA_W-1:0] s_writedata,
  input  logic [DATA_W-1:0] s_readdata
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t            r_state;
  logic              r_grant;
  logic              r_last_grant;
  logic              r_s_cs;
  logic              r_s_wn;
  logic [ADDR_W-1:0] r_s_addr;
  logic [DATA_W-1:0] r_s_wd;

  logic              w_pick;
  logic              w_next;
  logic              w_next_req;
  logic              w_serve;
  logic              w_sel_wn;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wd;

  // IDLE arbitration: a tie goes to the master that did not win last time,
  // or always to m0 when rotation is disabled.
  always_comb begin
    w_pick = m1_chipselect;
    if (m0_chipselect && m1_chipselect)
      w_pick = (ROUND_ROBIN != 0) ? ~r_last_grant : 1'b0;
  end

  // In ACCESS only the other master may take the next slot; the completing
  // master's chipselect still reflects the finishing transfer.
  assign w_next     = (r_state == IDLE) ? w_pick : ~r_grant;
  assign w_next_req = (r_state == IDLE) ? (m0_chipselect | m1_chipselect)
                                        : (r_grant ? m0_chipselect : m1_chipselect);
  assign w_sel_wn   = w_next ? m1_write_n   : m0_write_n;
  assign w_sel_addr = w_next ? m1_address   : m0_address;
  assign w_sel_wd   = w_next ? m1_writedata : m0_writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_grant      <= 1'b1;
      r_last_grant <= 1'b1;
      r_s_cs       <= 1'b0;
      r_s_wn       <= 1'b1;
      r_s_addr     <= '0;
      r_s_wd       <= '0;
    end else if (w_next_req) begin
      r_state      <= ACCESS;
      r_grant      <= w_next;
      r_last_grant <= w_next;
      r_s_cs       <= 1'b1;
      r_s_wn       <= w_sel_wn;
      r_s_addr     <= w_sel_addr;
      r_s_wd       <= w_sel_wd;
    end else begin
      r_state      <= IDLE;
      r_s_cs       <= 1'b0;
      r_s_wn       <= 1'b1;
    end
  end

  // A transfer caught by reset is not reported complete; the master keeps
  // stalling and is re-arbitrated afterwards.
  assign w_serve = (r_state == ACCESS) && !reset;

  assign m0_waitrequest = m0_chipselect & ~(w_serve & ~r_grant);
  assign m1_waitrequest = m1_chipselect & ~(w_serve &  r_grant);
  assign m0_readdata    = (w_serve && !r_grant) ? s_readdata : '0;
  assign m1_readdata    = (w_serve &&  r_grant) ? s_readdata : '0;

  assign s_chipselect = r_s_cs;
  assign s_write_n    = r_s_wn;
  assign s_address    = r_s_addr;
  assign s_writedata  = r_s_wd;

endmodule

// File: tb/tb_pcihellocore_hexport_arbiter.sv
// Scoreboard bench for the hex-port arbiter: one round-robin and one fixed-priority
// instance, each behind a behavioural hex PIO.
module tb_pcihellocore_hexport_arbiter;

  typedef struct {
    bit          wr;
    logic [1:0]  a;
    logic [31:0] data;
  } txn_t;

  logic        clk;
  logic        rst  [2];
  logic        cs   [2][2];
  logic        wn   [2][2];
  logic [1:0]  ad   [2][2];
  logic [31:0] wd   [2][2];
  logic [31:0] rd   [2][2];
  logic        wq   [2][2];
  logic        s_cs [2];
  logic        s_wn [2];
  logic [1:0]  s_ad [2];
  logic [31:0] s_wd [2];
  logic [31:0] s_rd [2];
  logic [31:0] pio  [2];

  int   n_chk, n_fail, cyc;
  txn_t exp_q [4][$];
  int   log_m [2][$];
  int   log_c [2][$];

  // monitor state
  logic [31:0] ref_mem [2];
  int          act_f [4], t0 [4], oth0 [4];
  int          alt_due [2], alt_m [2];
  int          done_m, k, w;
  txn_t        mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pcihellocore_hexport_arbiter #(.DATA_W(32), .ADDR_W(2), .ROUND_ROBIN(1)) u_rr (
    .clk(clk), .reset(rst[0]),
    .m0_chipselect(cs[0][0]), .m0_write_n(wn[0][0]), .m0_address(ad[0][0]),
    .m0_writedata(wd[0][0]), .m0_readdata(rd[0][0]), .m0_waitrequest(wq[0][0]),
    .m1_chipselect(cs[0][1]), .m1_write_n(wn[0][1]), .m1_address(ad[0][1]),
    .m1_writedata(wd[0][1]), .m1_readdata(rd[0][1]), .m1_waitrequest(wq[0][1]),
    .s_chipselect(s_cs[0]), .s_write_n(s_wn[0]), .s_address(s_ad[0]),
    .s_writedata(s_wd[0]), .s_readdata(s_rd[0]));

  pcihellocore_hexport_arbiter #(.DATA_W(32), .ADDR_W(2), .ROUND_ROBIN(0)) u_fp (
    .clk(clk), .reset(rst[1]),
    .m0_chipselect(cs[1][0]), .m0_write_n(wn[1][0]), .m0_address(ad[1][0]),
    .m0_writedata(wd[1][0]), .m0_readdata(rd[1][0]), .m0_waitrequest(wq[1][0]),
    .m1_chipselect(cs[1][1]), .m1_write_n(wn[1][1]), .m1_address(ad[1][1]),
    .m1_writedata(wd[1][1]), .m1_readdata(rd[1][1]), .m1_waitrequest(wq[1][1]),
    .s_chipselect(s_cs[1]), .s_write_n(s_wn[1]), .s_address(s_ad[1]),
    .s_writedata(s_wd[1]), .s_readdata(s_rd[1]));

  // Hex PIO: one data register at address 0, other addresses read 0.
  assign s_rd[0] = (s_ad[0] == 2'd0) ? pio[0] : 32'h0;
  assign s_rd[1] = (s_ad[1] == 2'd0) ? pio[1] : 32'h0;
  always @(posedge clk)
    for (int d = 0; d < 2; d++)
      if (rst[d]) pio[d] <= 32'h0;
      else if (s_cs[d] && !s_wn[d] && s_ad[d] == 2'd0) pio[d] <= s_wd[d];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the issuing master's expectation whenever it sees a completion,
  // and checks latency and hand-over against the arbitration rules.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        act_f[2*d] = 0; act_f[2*d+1] = 0; alt_due[d] = -1; ref_mem[d] = 32'h0;
      end else begin
        done_m = -1;
        for (int m = 0; m < 2; m++) begin
          k = 2*d + m;
          if (!cs[d][m]) chk($sformatf("dut%0d_m%0d_idle_waitreq", d, m), {31'h0, wq[d][m]}, 32'h0);
          if (cs[d][m] && act_f[k] == 0) begin
            act_f[k] = 1; t0[k] = cyc; oth0[k] = int'(cs[d][1-m]);
          end
          if (cs[d][m] && !wq[d][m]) begin
            done_m = m;
            act_f[k] = 0;
            log_m[d].push_back(m);
            log_c[d].push_back(cyc);
            chk($sformatf("dut%0d_m%0d_sb_nonempty", d, m), {31'h0, exp_q[k].size() != 0}, 32'h1);
            if (exp_q[k].size() != 0) begin
              mon_e = exp_q[k].pop_front();
              chk($sformatf("dut%0d_m%0d_s_cs", d, m), {31'h0, s_cs[d]}, 32'h1);
              chk($sformatf("dut%0d_m%0d_s_write_n", d, m), {31'h0, s_wn[d]}, {31'h0, !mon_e.wr});
              chk($sformatf("dut%0d_m%0d_s_addr", d, m), {30'h0, s_ad[d]}, {30'h0, mon_e.a});
              if (mon_e.wr) begin
                chk($sformatf("dut%0d_m%0d_s_wdata", d, m), s_wd[d], mon_e.data);
                if (mon_e.a == 2'd0) ref_mem[d] = mon_e.data;
              end else begin
                chk($sformatf("dut%0d_m%0d_rdata", d, m), rd[d][m],
                    (mon_e.a == 2'd0) ? ref_mem[d] : 32'h0);
              end
            end
            w = cyc - t0[k];
            chk($sformatf("dut%0d_m%0d_latency_1to2", d, m), {31'h0, (w >= 1 && w <= 2)}, 32'h1);
            if (oth0[k] == 0) chk($sformatf("dut%0d_m%0d_latency_uncont", d, m), w, 1);
          end else begin
            chk($sformatf("dut%0d_m%0d_rdata_zero", d, m), rd[d][m], 32'h0);
          end
        end
        if (alt_due[d] == cyc) chk($sformatf("dut%0d_handover", d), done_m, alt_m[d]);
        alt_due[d] = -1;
        if (done_m >= 0 && cs[d][1-done_m]) begin
          alt_due[d] = cyc + 1; alt_m[d] = 1 - done_m;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input int d, input int m, input bit w_, input logic [1:0] a,
                        input logic [31:0] data);
    int   n;
    txn_t e;
    e.wr = w_; e.a = a; e.data = data;
    exp_q[2*d+m].push_back(e);
    cs[d][m] = 1'b1; wn[d][m] = !w_; ad[d][m] = a; wd[d][m] = data;
    n = 0;
    @(negedge clk);
    while (wq[d][m] !== 1'b0 && n < 20) begin n++; @(negedge clk); end
    chk($sformatf("dut%0d_m%0d_done_in_budget", d, m), {31'h0, n < 20}, 32'h1);
    @(posedge clk); #1;
    cs[d][m] = 1'b0; wn[d][m] = 1'b1;
  endtask

  task automatic rand_master(input int d, input int m);
    for (int i = 0; i < 30; i++) begin
      step($urandom_range(0, 2));
      do_txn(d, m, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
    end
  endtask

  task automatic run_directed(input int d);
    int c0;
    logic [31:0] v;
    // host write then local read-back
    do_txn(d, 0, 1'b1, 2'd0, 32'h12345678);
    chk($sformatf("dut%0d_pio_after_m0_write", d), pio[d], 32'h12345678);
    do_txn(d, 1, 1'b0, 2'd0, 32'h0);
    step(2);
    // simultaneous writes: m0 first (m1 was last granted), m1 right behind
    log_m[d].delete(); log_c[d].delete();
    fork
      do_txn(d, 0, 1'b1, 2'd0, 32'hAAAA0000);
      do_txn(d, 1, 1'b1, 2'd0, 32'h0000BBBB);
    join
    step(2);
    chk($sformatf("dut%0d_tie_count", d), log_m[d].size(), 2);
    if (log_m[d].size() == 2) begin
      chk($sformatf("dut%0d_tie_first", d), log_m[d][0], 0);
      chk($sformatf("dut%0d_tie_gap", d), log_c[d][1] - log_c[d][0], 1);
    end
    chk($sformatf("dut%0d_pio_bbbb", d), pio[d], 32'h0000BBBB);
    // continuous contention: strict alternation, 5 each
    log_m[d].delete(); log_c[d].delete();
    fork
      for (int i = 0; i < 5; i++) do_txn(d, 0, 1'b1, 2'd1, 32'h100 + i);
      for (int i = 0; i < 5; i++) do_txn(d, 1, 1'b0, 2'd0, 32'h0);
    join
    step(2);
    chk($sformatf("dut%0d_burst_count", d), log_m[d].size(), 10);
    c0 = 0;
    foreach (log_m[d][i]) begin
      if (log_m[d][i] == 0) c0++;
      chk($sformatf("dut%0d_burst_seq%0d", d, i), log_m[d][i], i % 2);
    end
    chk($sformatf("dut%0d_burst_m0_share", d), c0, 5);
    // tie right after an m0-only grant: rotation favours m1, fixed priority m0
    do_txn(d, 0, 1'b1, 2'd3, 32'h5);
    step(2);
    log_m[d].delete(); log_c[d].delete();
    fork
      do_txn(d, 0, 1'b1, 2'd0, 32'h11111111);
      do_txn(d, 1, 1'b1, 2'd0, 32'h22222222);
    join
    step(2);
    chk($sformatf("dut%0d_prio_first", d), (log_m[d].size() != 0) ? log_m[d][0] : -1,
        (d == 0) ? 1 : 0);
    v = (d == 0) ? 32'h11111111 : 32'h22222222;
    chk($sformatf("dut%0d_pio_after_tie", d), pio[d], v);
    // read of an unmapped address
    do_txn(d, 1, 1'b0, 2'd2, 32'h0);
    chk($sformatf("dut%0d_pio_unchanged", d), pio[d], v);
    step(2);
    // reset lands in the ACCESS cycle of an m1 write
    log_m[d].delete(); log_c[d].delete();
    fork
      do_txn(d, 1, 1'b1, 2'd0, 32'hDEADBEEF);
      begin
        @(posedge clk); #1;
        rst[d] = 1'b1;
        @(negedge clk);
        chk($sformatf("dut%0d_rst_hold_wait", d), {31'h0, wq[d][1]}, 32'h1);
        @(posedge clk); #1;
        rst[d] = 1'b0;
        @(negedge clk);
        chk($sformatf("dut%0d_rst_drop_cs", d), {31'h0, s_cs[d]}, 32'h0);
        chk($sformatf("dut%0d_rst_still_wait", d), {31'h0, wq[d][1]}, 32'h1);
      end
    join
    step(2);
    chk($sformatf("dut%0d_rst_regrant", d), log_m[d].size(), 1);
    chk($sformatf("dut%0d_pio_deadbeef", d), pio[d], 32'hDEADBEEF);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      for (int m = 0; m < 2; m++) begin
        cs[d][m] = 1'b0; wn[d][m] = 1'b1; ad[d][m] = 2'd0; wd[d][m] = 32'h0;
      end
    end
    step(3);
    for (int d = 0; d < 2; d++) cs[d][0] = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dut%0d_rst_s_cs", d), {31'h0, s_cs[d]}, 32'h0);
      chk($sformatf("dut%0d_rst_s_wn", d), {31'h0, s_wn[d]}, 32'h1);
      chk($sformatf("dut%0d_rst_s_addr", d), {30'h0, s_ad[d]}, 32'h0);
      chk($sformatf("dut%0d_rst_s_wd", d), s_wd[d], 32'h0);
      chk($sformatf("dut%0d_rst_m0_wait_eq_cs", d), {31'h0, wq[d][0]}, 32'h1);
      chk($sformatf("dut%0d_rst_m0_rdata", d), rd[d][0], 32'h0);
      cs[d][0] = 1'b0;
    end
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) rst[d] = 1'b0;
    step(1);
    for (int d = 0; d < 2; d++) begin
      run_directed(d);
      step(2);
    end
    for (int d = 0; d < 2; d++) begin
      fork
        rand_master(d, 0);
        rand_master(d, 1);
      join
      step(3);
    end
    for (int k2 = 0; k2 < 4; k2++) chk($sformatf("sb_drained_%0d", k2), exp_q[k2].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
